// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the reaction timer: state encoding, BCD limits,
// next-state and flag decode functions.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_TIMING  = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

    typedef struct packed {
        logic busy;
        logic done;
        logic false_start;
        logic timeout;
    } flags_t;

    // arm overrides everything; press outranks both led_on and tick.
    function automatic state_t next_state(input state_t s, input logic arm,
                                          input logic press, input logic led_on,
                                          input logic tick, input logic at_max);
        state_t n = s;
        if (arm) begin
            n = ST_ARMED;
        end else begin
            case (s)
                ST_ARMED: begin
                    if (press)       n = ST_FAULT;
                    else if (led_on) n = ST_TIMING;
                end
                ST_TIMING: begin
                    if (press)                n = ST_DONE;
                    else if (tick && at_max)  n = ST_TIMEOUT;
                end
                default: n = s;
            endcase
        end
        return n;
    endfunction

    function automatic flags_t decode_flags(input state_t s);
        flags_t f;
        f.busy        = (s == ST_ARMED) || (s == ST_TIMING);
        f.done        = (s == ST_DONE);
        f.false_start = (s == ST_FAULT);
        f.timeout     = (s == ST_TIMEOUT);
        return f;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_digit.sv
// One decimal digit (0..9) of the millisecond counter; carry_out marks the
// terminal value so the parent can build the ripple enable chain.
module reaction_timer_bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_reg <= 4'd0;
        end else if (clr) begin
            digit_reg <= 4'd0;
        end else if (inc_in) begin
            digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    assign digit     = digit_reg;
    assign carry_out = (digit_reg == 4'd9);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-game timer: waits for the stimulus LED, then counts milliseconds in
// BCD until the button press, flagging false starts and timeouts.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int PRE_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        led,
    input  logic        btn,
    output logic [15:0] ms_bcd,
    output logic        busy,
    output logic        done,
    output logic        false_start,
    output logic        timeout
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [2:0]            btn_sync_reg;
    logic                  led_reg;
    logic [PRE_W-1:0]      pre_reg;
    state_t                state_reg;
    state_t                state_next;
    flags_t                flags_reg;
    logic                  press;
    logic                  led_on;
    logic                  tick;
    logic                  at_max;
    logic                  clr;
    logic [BCD_DIGITS-1:0] inc_en;
    logic [BCD_DIGITS-1:0] nine;

    // Two flops of synchronisation plus one for the edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync_reg <= 3'b000;
            led_reg      <= 1'b0;
        end else begin
            btn_sync_reg <= {btn_sync_reg[1:0], btn};
            led_reg      <= led;
        end
    end

    assign press  = btn_sync_reg[1] & ~btn_sync_reg[2];
    assign led_on = led & ~led_reg;

    // Held at zero outside TIMING so every round starts a fresh millisecond.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_reg <= '0;
        end else if (state_reg != ST_TIMING || tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    assign tick   = (state_reg == ST_TIMING) && (pre_reg == PRE_LAST);
    assign at_max = &nine;
    assign clr    = arm || (state_reg == ST_ARMED);

    assign inc_en[0] = tick && !press && !arm && !at_max;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            if (gi > 0) begin : g_chain
                assign inc_en[gi] = inc_en[gi-1] & nine[gi-1];
            end
            reaction_timer_bcd_digit u_digit (
                .clk       (clk),
                .reset     (reset),
                .clr       (clr),
                .inc_in    (inc_en[gi]),
                .digit     (ms_bcd[4*gi +: 4]),
                .carry_out (nine[gi])
            );
        end
    endgenerate

    assign state_next = next_state(state_reg, arm, press, led_on, tick, at_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            flags_reg <= decode_flags(state_next);
        end
    end

    assign busy        = flags_reg.busy;
    assign done        = flags_reg.done;
    assign false_start = flags_reg.false_start;
    assign timeout     = flags_reg.timeout;

endmodule
